// File: rtl/sdram_mux_pkg.sv
// -----------------------------------------------------------------------------
// sdram_mux_pkg
//   Shared types and constants for the three-port SDRAM arbiter.
//   - state_t : arbiter FSM states
//   - kind_t  : kind of access latched at grant time
//   - P_CPU / P_SPR / P_AUX : port indices used by grant logic
//   - helper functions for modulo-3 pointer arithmetic (round-robin build,
//     selected by the SDRAM_MUX_RR_EN macro)
// -----------------------------------------------------------------------------
package sdram_mux_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        ARM,
        WAIT,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        WORD,
        QUAD,
        WRITE
    } kind_t;

    localparam logic [1:0] P_CPU = 2'd0;
    localparam logic [1:0] P_SPR = 2'd1;
    localparam logic [1:0] P_AUX = 2'd2;

    localparam int TIMEOUT_CYCLES_DEF = 255;

    // Reduce a value in 0..5 to 0..2 (pointer + offset, modulo 3).
    function automatic logic [1:0] wrap3(input logic [2:0] v);
        return (v >= 3'd3) ? 2'(v - 3'd3) : v[1:0];
    endfunction

    // Port that follows p in the circular order 0 -> 1 -> 2 -> 0.
    function automatic logic [1:0] next_port(input logic [1:0] p);
        return (p == P_AUX) ? P_CPU : p + 2'd1;
    endfunction

endpackage

// File: rtl/sdram_mux_prio.sv
// -----------------------------------------------------------------------------
// sdram_mux_prio
//   Combinational 3-way grant selector.
//   Build option: SDRAM_MUX_RR_EN
//     defined   : round-robin, rr_ptr names the highest-priority port and the
//                 search runs rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3)
//     undefined : fixed priority req[0] > req[1] > req[2]; rr_ptr is ignored
//   Ports:
//     req    in  3  request vector, bit n = port n
//     rr_ptr in  2  current round-robin pointer
//     grant  out 2  selected port index (meaningful only when valid)
//     valid  out 1  at least one request present
// -----------------------------------------------------------------------------
module sdram_mux_prio
    import sdram_mux_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] rr_ptr,
    output logic [1:0] grant,
    output logic       valid
);

`ifdef SDRAM_MUX_RR_EN
    logic [1:0] idx;

    // Scan from the farthest candidate back to the pointer so the candidate
    // nearest the pointer is the last (winning) assignment.
    always_comb begin
        // NOTE: every output of a combinational block gets a default before
        // any conditional assignment, otherwise a latch is inferred.
        grant = P_CPU;
        valid = 1'b0;
        idx   = P_CPU;
        for (int k = 2; k >= 0; k--) begin
            idx = wrap3({1'b0, rr_ptr} + 3'(k));
            if (req[idx]) begin
                grant = idx;
                valid = 1'b1;
            end
        end
    end
`else
    logic unused_rr;
    assign unused_rr = ^rr_ptr;

    always_comb begin
        valid = |req;
        if (req[0])      grant = P_CPU;
        else if (req[1]) grant = P_SPR;
        else             grant = P_AUX;
    end
`endif

endmodule

// File: rtl/sdram_mux.sv
// -----------------------------------------------------------------------------
// sdram_mux
//   Shares one burst-4 SDRAM controller between the 68k CPU (word read/write,
//   port 0), the sprite fetcher (quad read, port 1) and an auxiliary word-read
//   port (port 2). One access at a time: IDLE -> ISSUE -> ARM -> WAIT -> DONE.
//   Build option: SDRAM_MUX_RR_EN selects round-robin arbitration instead of
//   fixed priority p0 > p1 > p2.
//   Ports:
//     clk, nRESET           clock (shared with controller), async active-low reset
//     p0_req/we/addr/din/wtbt  CPU request, held until p0_ack
//     p0_ack, p0_dout       CPU completion pulse and read data (held)
//     p1_req/addr           sprite quad-read request
//     p1_ack, p1_dout       completion pulse, four words, first in [63:48]
//     p2_req/addr           aux word-read request
//     p2_ack, p2_dout       completion pulse and read data
//     timeout_err           pulses with the ack of a forced completion
//     sd_addr/din/wtbt/rd/we   controller command side (all registered)
//     sd_dout, sd_ready_word, sd_ready_quad   controller response side
// -----------------------------------------------------------------------------
module sdram_mux
    import sdram_mux_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        nRESET,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [24:0] p0_addr,
    input  logic [15:0] p0_din,
    input  logic [1:0]  p0_wtbt,
    output logic        p0_ack,
    output logic [15:0] p0_dout,
    input  logic        p1_req,
    input  logic [24:0] p1_addr,
    output logic        p1_ack,
    output logic [63:0] p1_dout,
    input  logic        p2_req,
    input  logic [24:0] p2_addr,
    output logic        p2_ack,
    output logic [15:0] p2_dout,
    output logic        timeout_err,
    output logic [24:0] sd_addr,
    output logic [15:0] sd_din,
    output logic [1:0]  sd_wtbt,
    output logic        sd_rd,
    output logic        sd_we,
    input  logic [63:0] sd_dout,
    input  logic        sd_ready_word,
    input  logic        sd_ready_quad
);

    // WAIT has lasted TIMEOUT_CYCLES cycles when the counter shows this value.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state;
    kind_t       kind_q;
    logic [1:0]  gnt_q;
    logic [7:0]  tmo_q;
    logic [1:0]  rr_ptr;

    logic [1:0]  pick;
    logic        pick_valid;
    logic [24:0] pick_addr;
    kind_t       pick_kind;
    logic        grant_now;
    logic        ready_hit;

    sdram_mux_prio u_prio (
        .req    ({p2_req, p1_req, p0_req}),
        .rr_ptr (rr_ptr),
        .grant  (pick),
        .valid  (pick_valid)
    );

    always_comb begin
        pick_addr = p0_addr;
        pick_kind = p0_we ? WRITE : WORD;
        case (pick)
            P_SPR: begin
                pick_addr = p1_addr;
                pick_kind = QUAD;
            end
            P_AUX: begin
                pick_addr = p2_addr;
                pick_kind = WORD;
            end
            default: ;
        endcase
    end

    // ready_word low in IDLE means the controller is still initialising.
    assign grant_now = (state == IDLE) && pick_valid && sd_ready_word;
    assign ready_hit = (kind_q == QUAD) ? sd_ready_quad : sd_ready_word;

`ifdef SDRAM_MUX_RR_EN
    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET)        rr_ptr <= P_CPU;
        else if (grant_now) rr_ptr <= next_port(pick);
    end
`else
    assign rr_ptr = P_CPU;
`endif

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the values from before this edge, regardless of statement order.
    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            state       <= IDLE;
            kind_q      <= WORD;
            gnt_q       <= P_CPU;
            tmo_q       <= '0;
            sd_addr     <= '0;
            sd_din      <= '0;
            sd_wtbt     <= '0;
            sd_rd       <= 1'b0;
            sd_we       <= 1'b0;
            p0_ack      <= 1'b0;
            p1_ack      <= 1'b0;
            p2_ack      <= 1'b0;
            timeout_err <= 1'b0;
            p0_dout     <= '0;
            p1_dout     <= '0;
            p2_dout     <= '0;
        end else begin
            // Acks and the error flag are single-cycle pulses.
            p0_ack      <= 1'b0;
            p1_ack      <= 1'b0;
            p2_ack      <= 1'b0;
            timeout_err <= 1'b0;

            case (state)
                IDLE: begin
                    if (grant_now) begin
                        gnt_q   <= pick;
                        kind_q  <= pick_kind;
                        sd_addr <= pick_addr;
                        sd_din  <= (pick == P_CPU) ? p0_din  : '0;
                        sd_wtbt <= (pick == P_CPU) ? p0_wtbt : '0;
                        // Strobe is high for exactly the ISSUE cycle.
                        if (pick_kind == WRITE) sd_we <= 1'b1;
                        else                    sd_rd <= 1'b1;
                        state <= ISSUE;
                    end
                end

                ISSUE: begin
                    sd_rd <= 1'b0;
                    sd_we <= 1'b0;
                    tmo_q <= '0;
                    state <= ARM;
                end

                // Guaranteed low strobe phase; also gives the controller a
                // cycle to drop its ready flag before WAIT samples it.
                ARM: state <= WAIT;

                WAIT: begin
                    if (ready_hit || tmo_q == TMO_LAST) begin
                        timeout_err <= !ready_hit;
                        case (gnt_q)
                            P_SPR: begin
                                p1_ack  <= 1'b1;
                                p1_dout <= sd_dout;
                            end
                            P_AUX: begin
                                p2_ack  <= 1'b1;
                                p2_dout <= sd_dout[63:48];
                            end
                            default: begin
                                p0_ack <= 1'b1;
                                if (kind_q != WRITE) p0_dout <= sd_dout[63:48];
                            end
                        endcase
                        state <= DONE;
                    end else begin
                        tmo_q <= tmo_q + 8'd1;
                    end
                end

                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
